// File: rtl/sram_cmd_pkg.sv
// Shared opcodes, response bytes and FSM encoding for the UART-to-SRAM command parser.
package sram_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR2 = 3'd1,
    ST_ADDR1 = 3'd2,
    ST_ADDR0 = 3'd3,
    ST_DATA  = 3'd4,
    ST_MEM   = 3'd5,
    ST_TX    = 3'd6
  } state_t;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_OK   = 8'h4B;
  localparam logic [7:0] RSP_ERR  = 8'h3F;

  function automatic logic is_opcode(input logic [7:0] b);
    return (b == OP_WRITE) || (b == OP_READ);
  endfunction

  // States in which the parser is waiting for the rest of a frame.
  function automatic logic in_frame(input state_t s);
    return (s == ST_ADDR2) || (s == ST_ADDR1) || (s == ST_ADDR0) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/idle_timer.sv
// Inter-byte timeout counter; expired is a same-cycle flag so a byte arriving
// on the expiry cycle can still take priority in the parser.
module idle_timer #(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  assign expired = en && (r_count == LAST);

  // Counter idles at zero outside a frame and restarts on every accepted byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clr || !en || expired) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses 'W' A2 A1 A0 D / 'R' A2 A1 A0 frames from a UART byte stream into one
// SRAM access and answers with 'K', the read byte, or '?' for an unknown opcode.
module uart_cmd_parser
  import sram_cmd_pkg::*;
#(
  parameter int ADDR_WIDTH     = 19,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_done_tick,
  input  logic [7:0]            r_data,
  input  logic                  tx_ready,
  output logic                  tx_start,
  output logic [7:0]            w_data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic                  mem_ack,
  input  logic [7:0]            mem_rdata,
  output logic                  busy,
  output logic                  rx_overrun
);

  state_t r_state;
  state_t w_state_nxt;

  logic w_timer_en, w_accept, w_expired;
  logic w_ld_op, w_ld_a2, w_ld_a1, w_ld_a0, w_ld_wd, w_ld_tx, w_overrun;
  logic [7:0] w_tx_byte;

  logic                  r_tx_start, r_mem_req, r_mem_we, r_busy, r_rx_overrun;
  logic [7:0]            r_w_data, r_mem_wdata;
  logic [ADDR_WIDTH-1:0] r_mem_addr;

  assign w_timer_en = in_frame(r_state);
  assign w_accept   = rx_done_tick && ((r_state == ST_IDLE) || w_timer_en);

  idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_idle_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (w_accept),
    .en      (w_timer_en),
    .expired (w_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; an arriving byte beats a simultaneous timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (rx_done_tick) w_state_nxt = is_opcode(r_data) ? ST_ADDR2 : ST_TX;
        else              w_state_nxt = ST_IDLE;
      end
      ST_ADDR2: begin
        if (rx_done_tick)   w_state_nxt = ST_ADDR1;
        else if (w_expired) w_state_nxt = ST_IDLE;
        else                w_state_nxt = ST_ADDR2;
      end
      ST_ADDR1: begin
        if (rx_done_tick)   w_state_nxt = ST_ADDR0;
        else if (w_expired) w_state_nxt = ST_IDLE;
        else                w_state_nxt = ST_ADDR1;
      end
      ST_ADDR0: begin
        if (rx_done_tick)   w_state_nxt = r_mem_we ? ST_DATA : ST_MEM;
        else if (w_expired) w_state_nxt = ST_IDLE;
        else                w_state_nxt = ST_ADDR0;
      end
      ST_DATA: begin
        if (rx_done_tick)   w_state_nxt = ST_MEM;
        else if (w_expired) w_state_nxt = ST_IDLE;
        else                w_state_nxt = ST_DATA;
      end
      ST_MEM: begin
        if (mem_ack) w_state_nxt = ST_TX;
        else         w_state_nxt = ST_MEM;
      end
      ST_TX: begin
        if (tx_ready) w_state_nxt = ST_IDLE;
        else          w_state_nxt = ST_TX;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: which datapath register loads this cycle.
  always_comb begin
    w_ld_op   = 1'b0;
    w_ld_a2   = 1'b0;
    w_ld_a1   = 1'b0;
    w_ld_a0   = 1'b0;
    w_ld_wd   = 1'b0;
    w_ld_tx   = 1'b0;
    w_overrun = 1'b0;
    w_tx_byte = RSP_ERR;
    case (r_state)
      ST_IDLE: begin
        w_ld_op = rx_done_tick && is_opcode(r_data);
        w_ld_tx = rx_done_tick && !is_opcode(r_data);
      end
      ST_ADDR2: w_ld_a2 = rx_done_tick;
      ST_ADDR1: w_ld_a1 = rx_done_tick;
      ST_ADDR0: w_ld_a0 = rx_done_tick;
      ST_DATA:  w_ld_wd = rx_done_tick;
      ST_MEM: begin
        w_overrun = rx_done_tick;
        w_ld_tx   = mem_ack;
        w_tx_byte = r_mem_we ? RSP_OK : mem_rdata;
      end
      ST_TX:   w_overrun = rx_done_tick;
      default: w_overrun = 1'b0;
    endcase
  end

  // Registered outputs; upper A2 bits beyond the address width are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_start   <= 1'b0;
      r_w_data     <= 8'h00;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 8'h00;
      r_busy       <= 1'b0;
      r_rx_overrun <= 1'b0;
    end else begin
      r_tx_start <= (r_state == ST_TX) && tx_ready;
      r_mem_req  <= (w_state_nxt == ST_MEM);
      r_busy     <= (w_state_nxt != ST_IDLE);
      if (w_overrun) r_rx_overrun <= 1'b1;
      if (w_ld_op)   r_mem_we <= (r_data == OP_WRITE);
      if (w_ld_a2)   r_mem_addr[ADDR_WIDTH-1:16] <= r_data[ADDR_WIDTH-17:0];
      if (w_ld_a1)   r_mem_addr[15:8] <= r_data;
      if (w_ld_a0)   r_mem_addr[7:0] <= r_data;
      if (w_ld_wd)   r_mem_wdata <= r_data;
      if (w_ld_tx)   r_w_data <= w_tx_byte;
    end
  end

  assign tx_start   = r_tx_start;
  assign w_data     = r_w_data;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign busy       = r_busy;
  assign rx_overrun = r_rx_overrun;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed plus randomized bench for uart_cmd_parser with a behavioural SRAM/frame model.
module tb_uart_cmd_parser;

  localparam int AW = 19;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_done_tick;
  logic [7:0]    r_data;
  logic          tx_ready;
  logic          tx_start;
  logic [7:0]    w_data;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_ack;
  logic [7:0]    mem_rdata;
  logic          busy;
  logic          rx_overrun;

  int checks = 0;
  int errors = 0;
  int n_tx   = 0;
  int n_req  = 0;

  logic [7:0] sram [logic [AW-1:0]];

  always #5 clk = ~clk;

  uart_cmd_parser #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .r_data       (r_data),
    .tx_ready     (tx_ready),
    .tx_start     (tx_start),
    .w_data       (w_data),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .busy         (busy),
    .rx_overrun   (rx_overrun)
  );

  always @(posedge clk) begin
    n_tx  <= n_tx + (tx_start ? 1 : 0);
    n_req <= n_req + (mem_req ? 1 : 0);
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    r_data       = b;
    rx_done_tick = 1'b1;
    tick(1);
    rx_done_tick = 1'b0;
    r_data       = 8'($urandom);
  endtask

  function automatic logic [7:0] model_rd(input logic [AW-1:0] a);
    if (sram.exists(a)) return sram[a];
    else return a[7:0] ^ 8'hA5;
  endfunction

  // Wait (bounded) for the single response pulse and check byte and count.
  task automatic expect_tx(input logic [7:0] exp_b, input int n0);
    logic       seen;
    logic [7:0] got;
    seen = 1'b0;
    got  = 8'h00;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick(1);
      if (tx_start) begin
        seen = 1'b1;
        got  = w_data;
      end
    end
    check("tx_seen", seen, 1);
    check("tx_byte", got, exp_b);
    tick(3);
    check("tx_once", n_tx - n0, 1);
    check("w_data_hold", w_data, exp_b);
    check("idle_after_tx", busy, 0);
  endtask

  task automatic do_access(input logic is_wr, input logic [7:0] a2, input logic [7:0] a1,
                           input logic [7:0] a0, input logic [7:0] d, input int gap,
                           input int ack_dly, output logic [7:0] exp_b, output int n0);
    logic [AW-1:0] ea;
    logic [7:0]    rd;
    logic          hold_ok;
    ea = AW'((int'(a2) * 65536 + int'(a1) * 256 + int'(a0)) % 524288);
    send_byte(is_wr ? 8'h57 : 8'h52);
    tick(gap); send_byte(a2);
    check("busy_in_frame", busy, 1);
    tick(gap); send_byte(a1);
    tick(gap); send_byte(a0);
    if (is_wr) begin
      tick(gap);
      send_byte(d);
    end
    check("req_rise", mem_req, 1);
    check("mem_we", mem_we, is_wr);
    check("mem_addr", mem_addr, ea);
    if (is_wr) check("mem_wdata", mem_wdata, d);
    hold_ok = 1'b1;
    repeat (ack_dly) begin
      tick(1);
      if (!(mem_req && mem_we == is_wr && mem_addr == ea && (!is_wr || mem_wdata == d)))
        hold_ok = 1'b0;
    end
    check("req_hold", hold_ok, 1);
    rd        = model_rd(ea);
    mem_rdata = is_wr ? 8'($urandom) : rd;
    mem_ack   = 1'b1;
    n0        = n_tx;
    tick(1);
    mem_ack   = 1'b0;
    mem_rdata = 8'($urandom);
    check("req_fall", mem_req, 0);
    if (is_wr) sram[ea] = d;
    exp_b = is_wr ? 8'h4B : rd;
  endtask

  task automatic bad_byte(input logic [7:0] b);
    int n0;
    int q0;
    n0 = n_tx;
    q0 = n_req;
    send_byte(b);
    check("bad_no_req", mem_req, 0);
    expect_tx(8'h3F, n0);
    check("bad_no_access", n_req - q0, 0);
  endtask

  initial begin
    logic [7:0] eb;
    logic [7:0] b;
    int         n0;
    int         q0;
    int         sel;

    reset = 1'b0; rx_done_tick = 1'b0; r_data = 8'h00;
    tx_ready = 1'b1; mem_ack = 1'b0; mem_rdata = 8'h00;
    tick(3);
    check("rst_tx_start", tx_start, 0);
    check("rst_w_data", w_data, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", rx_overrun, 0);
    reset = 1'b1;
    tick(2);
    sram[19'h7FFFF] = 8'h3C;

    // Reference write and reads, including A2 high bits ignored.
    do_access(1'b1, 8'h00, 8'h12, 8'h34, 8'hA5, 1, 3, eb, n0);
    expect_tx(eb, n0);
    do_access(1'b0, 8'h07, 8'hFF, 8'hFF, 8'h00, 0, 2, eb, n0);
    expect_tx(eb, n0);
    do_access(1'b0, 8'hFF, 8'hFF, 8'hFF, 8'h00, 2, 0, eb, n0);
    expect_tx(eb, n0);
    bad_byte(8'h41);

    // Silence after partial frame: abort with no access or response.
    n0 = n_tx;
    q0 = n_req;
    send_byte(8'h57);
    send_byte(8'h00);
    tick(TO - 5);
    check("to_still_busy", busy, 1);
    tick(15);
    check("to_idle", busy, 0);
    check("to_no_req", n_req - q0, 0);
    check("to_no_tx", n_tx - n0, 0);

    // Bytes landing exactly on the expiry cycle are accepted.
    do_access(1'b1, 8'h03, 8'h00, 8'h10, 8'h5E, TO - 1, 1, eb, n0);
    expect_tx(eb, n0);

    // Transmitter stalled with an extra byte arriving in TX.
    tx_ready = 1'b0;
    do_access(1'b1, 8'h01, 8'h02, 8'h03, 8'h77, 0, 2, eb, n0);
    tick(20);
    send_byte(8'h52);
    tick(29);
    check("stall_no_tx", n_tx - n0, 0);
    check("stall_busy", busy, 1);
    check("overrun_set", rx_overrun, 1);
    tx_ready = 1'b1;
    expect_tx(eb, n0);
    check("overrun_sticky", rx_overrun, 1);

    // Randomized mix of writes, reads and junk bytes.
    for (int i = 0; i < 24; i++) begin
      sel = int'($urandom_range(0, 3));
      if (sel == 0) begin
        b = 8'($urandom);
        if (b == 8'h57 || b == 8'h52) b = 8'h00;
        bad_byte(b);
      end else begin
        do_access(sel == 1, {5'($urandom), 3'b101}, 8'($urandom_range(0, 1)),
                  8'($urandom_range(0, 3)), 8'($urandom), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 5)), eb, n0);
        expect_tx(eb, n0);
      end
    end

    // Asynchronous reset during an outstanding access.
    send_byte(8'h52); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    check("pre_rst_req", mem_req, 1);
    #3 reset = 1'b0;
    #1;
    check("arst_mem_req", mem_req, 0);
    check("arst_busy", busy, 0);
    check("arst_w_data", w_data, 0);
    check("arst_mem_addr", mem_addr, 0);
    check("arst_mem_we", mem_we, 0);
    check("arst_mem_wdata", mem_wdata, 0);
    check("arst_overrun", rx_overrun, 0);
    check("arst_tx_start", tx_start, 0);
    @(posedge clk);
    #1;
    tick(2);
    reset = 1'b1;
    n0 = n_tx;
    q0 = n_req;
    tick(1);
    mem_ack = 1'b1;
    mem_rdata = 8'h99;
    tick(1);
    mem_ack = 1'b0;
    tick(20);
    check("post_rst_no_tx", n_tx - n0, 0);
    check("post_rst_no_req", n_req - q0, 0);
    check("post_rst_idle", busy, 0);
    check("post_rst_w_data", w_data, 0);

    do_access(1'b1, 8'h02, 8'hAB, 8'hCD, 8'h11, 1, 1, eb, n0);
    expect_tx(eb, n0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
